// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } reset_seq_state_e;

    // Lock-loss status counter width and saturation value
    localparam int         RELOCK_W   = 8;
    localparam logic [7:0] RELOCK_MAX = 8'hFF;

    // Width of a counter that holds 0..n-1; never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_cdc_bit_sync.sv
// Single-bit synchronizer: SYNC_STAGE flop chain, clears to 0 on reset.
module cdc_bit_sync #(
    parameter int SYNC_STAGE = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;

    // Shift the asynchronous input through the chain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGE-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release for one clock domain. Waits for a filtered MMCM lock,
// then drops stage_reset[0], [1], ... one HOLD_CYCLES gap apart.
// Optional status counter: define RESET_SEQ_STATUS_EN to add relock_count.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SYNC_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  mmcm_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  all_released
`ifdef RESET_SEQ_STATUS_EN
    ,
    output logic [RELOCK_W-1:0]   relock_count
`endif
);

    localparam int TIMER_W = clog2_min1(HOLD_CYCLES);
    localparam int FILT_W  = clog2_min1(LOCK_FILTER);
    localparam int IDX_W   = clog2_min1(NUM_STAGES);

    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0]     FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

    logic [SYNC_STAGE-1:0] rst_sync_q;
    logic                  rst_int;
    logic                  lock_s;

    reset_seq_state_e      state_q, state_d;
    logic [FILT_W-1:0]     filt_q,  filt_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  all_q,   all_d;

`ifdef RESET_SEQ_STATUS_EN
    logic                  relock_inc;
    logic [RELOCK_W-1:0]   relock_q, relock_d;
`endif

    // Internal reset: asserts with async_reset, releases after SYNC_STAGE edges.
    // Everything below uses rst_int, so async_reset still takes effect with no clock.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) rst_sync_q <= '1;
        else             rst_sync_q <= {rst_sync_q[SYNC_STAGE-2:0], 1'b0};
    end

    assign rst_int = rst_sync_q[SYNC_STAGE-1];

    // The lock synchronizer is reset by the raw input so it fills while the
    // internal reset is still draining; best-case release then needs no extra wait.
    cdc_bit_sync #(
        .SYNC_STAGE (SYNC_STAGE)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_i (async_reset),
        .d_i   (mmcm_locked),
        .q_o   (lock_s)
    );

    // Next-state logic: lock filter, release timer/index, restart on lock loss or soft request
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        all_d   = all_q;
`ifdef RESET_SEQ_STATUS_EN
        relock_inc = 1'b0;
`endif
        unique case (state_q)
            HOLD: begin
                state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_LAST) begin
                    state_d = RELEASE;
                    filt_d  = '0;
                    timer_d = '0;
                    idx_d   = '0;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (!lock_s || soft_reset_req) begin
                    // Full restart; lock loss wins when both happen together
                    state_d = WAIT_LOCK;
                    filt_d  = '0;
                    timer_d = '0;
                    idx_d   = '0;
                    stage_d = '1;
                    all_d   = 1'b0;
`ifdef RESET_SEQ_STATUS_EN
                    relock_inc = !lock_s;
`endif
                end else if (state_q == RELEASE) begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        stage_d = stage_q & ~(STAGE_ONE << idx_q);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            all_d   = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Sequencer registers, held in HOLD with all stages in reset
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= HOLD;
            filt_q  <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            stage_q <= '1;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            all_q   <= all_d;
        end
    end

    assign stage_reset  = stage_q;
    assign all_released = all_q;

`ifdef RESET_SEQ_STATUS_EN
    // Saturating count of lock losses seen while releasing or running
    always_comb begin
        relock_d = relock_q;
        if (relock_inc && (relock_q != RELOCK_MAX)) relock_d = relock_q + 1'b1;
    end

    // Status counter; only a hard reset clears it
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) relock_q <= '0;
        else         relock_q <= relock_d;
    end

    assign relock_count = relock_q;
`endif

endmodule
